// File: rtl/phased_cache_pkg.sv
// rtl/phased_cache_pkg.sv - shared types, widths and hit-vector decode for the phased cache way select
package phased_cache_pkg;

   localparam int WAY_BITS = 3;
   localparam int NUM_WAYS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAG  = 2'd1,
      MISS = 2'd2,
      DATA = 2'd3
   } state_e;

   typedef struct packed {
      logic [WAY_BITS-1:0] idx;
      logic                multi;
   } hit_dec_t;

   // Lowest set bit wins so a corrupted multi-hit still resolves deterministically.
   function automatic hit_dec_t onehot_lowest_to_idx(input logic [NUM_WAYS-1:0] vec);
      hit_dec_t res;
      res.idx   = '0;
      res.multi = ((vec & (vec - 1'b1)) != '0);
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            res.idx = WAY_BITS'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/phased_way_select_if.sv
// rtl/phased_way_select_if.sv - request, tag, fill and data-way signals between requester/arrays and the way select
interface phased_way_select_if
   import phased_cache_pkg::*;
#(
   parameter int SET_BITS = 6
);
   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [SET_BITS-1:0] req_set;
   logic                tag_rd_en;
   logic [NUM_WAYS-1:0] tag_hit;
   logic                miss_req;
   logic [WAY_BITS-1:0] miss_way;
   logic                fill_done;
   logic                way_en;
   logic [WAY_BITS-1:0] way_idx;
   logic                data_we;
   logic                resp_valid;
   logic                resp_hit;
   logic                multi_hit_err;

   modport master (
      output req_valid, req_write, req_set, tag_hit, fill_done,
      input  req_ready, tag_rd_en, miss_req, miss_way, way_en, way_idx,
             data_we, resp_valid, resp_hit, multi_hit_err
   );

   modport slave (
      input  req_valid, req_write, req_set, tag_hit, fill_done,
      output req_ready, tag_rd_en, miss_req, miss_way, way_en, way_idx,
             data_we, resp_valid, resp_hit, multi_hit_err
   );
endinterface

// File: rtl/rr_victim_table.sv
// rtl/rr_victim_table.sv - per-set round-robin victim pointers, one read port and one increment port
module rr_victim_table
   import phased_cache_pkg::*;
#(
   parameter int SET_BITS = 6
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [SET_BITS-1:0] i_rd_set,
   output logic [WAY_BITS-1:0] o_rd_ptr,
   input  logic                i_inc,
   input  logic [SET_BITS-1:0] i_inc_set
);
   logic [WAY_BITS-1:0] r_ptr [2**SET_BITS];

   assign o_rd_ptr = r_ptr[i_rd_set];

   // 3-bit add wraps 7 back to 0 on its own.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 2**SET_BITS; i++) begin
            r_ptr[i] <= '0;
         end
      end else if (i_inc) begin
         r_ptr[i_inc_set] <= r_ptr[i_inc_set] + 1'b1;
      end
   end
endmodule

// File: rtl/phased_way_select.sv
// rtl/phased_way_select.sv - two-phase tag/data control with round-robin miss victim and fill handshake
module phased_way_select
   import phased_cache_pkg::*;
#(
   parameter int SET_BITS = 6,
   parameter int NUM_WAYS = 8
) (
   input  logic               clk,
   input  logic               reset,
   phased_way_select_if.slave bus
);
   if (NUM_WAYS != phased_cache_pkg::NUM_WAYS) begin : g_num_ways_fixed
      $error("phased_way_select: NUM_WAYS is tied to the 3-to-8 data-way decoder and must be 8");
   end

   state_e              r_state;
   logic [SET_BITS-1:0] r_set;
   logic                r_write;
   logic                r_tag_rd_en;
   logic                r_miss_req;
   logic [WAY_BITS-1:0] r_miss_way;
   logic                r_way_en;
   logic [WAY_BITS-1:0] r_way_idx;
   logic                r_data_we;
   logic                r_resp_valid;
   logic                r_resp_hit;
   logic                r_multi_hit_err;

   logic [WAY_BITS-1:0] w_rr_ptr;
   logic                w_rr_inc;
   hit_dec_t            w_hit_dec;

   assign w_hit_dec = onehot_lowest_to_idx(bus.tag_hit);
   assign w_rr_inc  = (r_state == MISS) && bus.fill_done;

   rr_victim_table #(.SET_BITS(SET_BITS)) u_rr_victim_table (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_rd_set  (r_set),
      .o_rd_ptr  (w_rr_ptr),
      .i_inc     (w_rr_inc),
      .i_inc_set (r_set)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_set           <= '0;
         r_write         <= 1'b0;
         r_tag_rd_en     <= 1'b0;
         r_miss_req      <= 1'b0;
         r_miss_way      <= '0;
         r_way_en        <= 1'b0;
         r_way_idx       <= '0;
         r_data_we       <= 1'b0;
         r_resp_valid    <= 1'b0;
         r_resp_hit      <= 1'b0;
         r_multi_hit_err <= 1'b0;
      end else begin
         // Strobes default low; way_idx, miss_way and resp_hit hold.
         r_tag_rd_en  <= 1'b0;
         r_way_en     <= 1'b0;
         r_data_we    <= 1'b0;
         r_resp_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_set       <= bus.req_set;
                  r_write     <= bus.req_write;
                  r_tag_rd_en <= 1'b1;
                  r_state     <= TAG;
               end
            end
            TAG: begin
               if (bus.tag_hit != '0) begin
                  r_way_idx    <= w_hit_dec.idx;
                  r_resp_hit   <= 1'b1;
                  r_way_en     <= 1'b1;
                  r_data_we    <= r_write;
                  r_resp_valid <= 1'b1;
                  if (w_hit_dec.multi) begin
                     r_multi_hit_err <= 1'b1;
                  end
                  r_state <= DATA;
               end else begin
                  r_miss_way <= w_rr_ptr;
                  r_miss_req <= 1'b1;
                  r_state    <= MISS;
               end
            end
            MISS: begin
               if (bus.fill_done) begin
                  r_way_idx    <= r_miss_way;
                  r_miss_req   <= 1'b0;
                  r_resp_hit   <= 1'b0;
                  r_way_en     <= 1'b1;
                  r_data_we    <= r_write;
                  r_resp_valid <= 1'b1;
                  r_state      <= DATA;
               end
            end
            DATA: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready     = (r_state == IDLE);
   assign bus.tag_rd_en     = r_tag_rd_en;
   assign bus.miss_req      = r_miss_req;
   assign bus.miss_way      = r_miss_way;
   assign bus.way_en        = r_way_en;
   assign bus.way_idx       = r_way_idx;
   assign bus.data_we       = r_data_we;
   assign bus.resp_valid    = r_resp_valid;
   assign bus.resp_hit      = r_resp_hit;
   assign bus.multi_hit_err = r_multi_hit_err;
endmodule

// File: tb/tb_phased_way_select.sv
// tb/tb_phased_way_select.sv - bench for phased_way_select against a per-set pointer model
module tb_phased_way_select;
   logic clk = 1'b0;
   logic reset;

   phased_way_select_if #(.SET_BITS(6)) bus ();

   phased_way_select #(.SET_BITS(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int ptr [64];
   bit multi_seen = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_cleared(input string pfx);
      check({pfx, "_req_ready"},  32'(bus.req_ready), 1);
      check({pfx, "_tag_rd_en"},  32'(bus.tag_rd_en), 0);
      check({pfx, "_miss_req"},   32'(bus.miss_req), 0);
      check({pfx, "_miss_way"},   32'(bus.miss_way), 0);
      check({pfx, "_way_en"},     32'(bus.way_en), 0);
      check({pfx, "_way_idx"},    32'(bus.way_idx), 0);
      check({pfx, "_data_we"},    32'(bus.data_we), 0);
      check({pfx, "_resp_valid"}, 32'(bus.resp_valid), 0);
      check({pfx, "_resp_hit"},   32'(bus.resp_hit), 0);
      check({pfx, "_multi_err"},  32'(bus.multi_hit_err), 0);
   endtask

   // One full access from IDLE back to IDLE; fd is the miss wait in cycles including the fill_done cycle.
   task automatic access(input int set, input int wr, input logic [7:0] hv, input int fd);
      int ones;
      int low;
      int victim;
      ones = $countones(hv);
      low  = 0;
      for (int b = 7; b >= 0; b--) if (hv[b]) low = b;
      check("idle_ready", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_set   = 6'(set);
      bus.req_write = wr[0];
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_set   = ~6'(set);
      bus.req_write = ~wr[0];
      check("tag_rd_en", 32'(bus.tag_rd_en), 1);
      check("tag_ready", 32'(bus.req_ready), 0);
      check("tag_way_en", 32'(bus.way_en), 0);
      bus.tag_hit = hv;
      @(negedge clk);
      bus.tag_hit = 8'h00;
      if (ones > 0) begin
         if (ones > 1) multi_seen = 1'b1;
         check("hit_way_en", 32'(bus.way_en), 1);
         check("hit_way_idx", 32'(bus.way_idx), 32'(low));
         check("hit_data_we", 32'(bus.data_we), 32'(wr));
         check("hit_resp_valid", 32'(bus.resp_valid), 1);
         check("hit_resp_hit", 32'(bus.resp_hit), 1);
         check("hit_tag_rd_en", 32'(bus.tag_rd_en), 0);
      end else begin
         victim = ptr[set];
         for (int k = 0; k < fd; k++) begin
            check("miss_req", 32'(bus.miss_req), 1);
            check("miss_way", 32'(bus.miss_way), 32'(victim));
            check("miss_way_en", 32'(bus.way_en), 0);
            if (k == fd - 1) bus.fill_done = 1'b1;
            @(negedge clk);
         end
         bus.fill_done = 1'b0;
         ptr[set] = (ptr[set] + 1) % 8;
         check("fill_way_en", 32'(bus.way_en), 1);
         check("fill_way_idx", 32'(bus.way_idx), 32'(victim));
         check("fill_data_we", 32'(bus.data_we), 32'(wr));
         check("fill_resp_valid", 32'(bus.resp_valid), 1);
         check("fill_resp_hit", 32'(bus.resp_hit), 0);
         check("fill_miss_req", 32'(bus.miss_req), 0);
      end
      check("data_multi_err", 32'(bus.multi_hit_err), 32'(multi_seen));
      @(negedge clk);
      check("post_way_en", 32'(bus.way_en), 0);
      check("post_data_we", 32'(bus.data_we), 0);
      check("post_resp_valid", 32'(bus.resp_valid), 0);
      check("post_ready", 32'(bus.req_ready), 1);
   endtask

   initial begin
      logic [7:0] hv;
      int r;
      int b0;
      int b1;
      for (int i = 0; i < 64; i++) ptr[i] = 0;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_set   = '0;
      bus.tag_hit   = 8'h00;
      bus.fill_done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_cleared("rst");

      access(5, 0, 8'b0010_0000, 0);
      access(3, 1, 8'b0000_0000, 4);
      access(3, 0, 8'b0000_0000, 1);

      for (int n = 0; n < 9; n++) access(7, n % 2, 8'b0000_0000, 1 + (n % 3));
      access(6, 0, 8'b0000_0000, 2);

      access(0, 0, 8'b1001_0000, 0);
      access(1, 1, 8'b0000_0001, 0);
      access(2, 0, 8'b0100_0000, 0);

      // Held request with hits: accepted every third cycle.
      bus.req_valid = 1'b1;
      bus.req_set   = 6'd9;
      bus.req_write = 1'b1;
      bus.tag_hit   = 8'b0000_0100;
      for (int k = 0; k < 9; k++) begin
         check("b2b_ready", 32'(bus.req_ready), 32'(k % 3 == 0));
         check("b2b_tag_rd_en", 32'(bus.tag_rd_en), 32'(k % 3 == 1));
         check("b2b_way_en", 32'(bus.way_en), 32'(k % 3 == 2));
         if (k % 3 == 2) check("b2b_way_idx", 32'(bus.way_idx), 2);
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      bus.tag_hit   = 8'h00;
      @(negedge clk);
      check("b2b_idle", 32'(bus.req_ready), 1);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 3);
         if (r == 0) hv = 8'h00;
         else if (r < 3) hv = 8'(1 << $urandom_range(0, 7));
         else begin
            b0 = $urandom_range(0, 7);
            b1 = (b0 + $urandom_range(1, 7)) % 8;
            hv = 8'(1 << b0) | 8'(1 << b1);
         end
         access($urandom_range(0, 7), $urandom_range(0, 1), hv, $urandom_range(1, 5));
      end

      // Reset while a fill is pending.
      bus.req_valid = 1'b1;
      bus.req_set   = 6'd7;
      bus.req_write = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.tag_hit   = 8'h00;
      @(negedge clk);
      check("pre_rst_miss_req", 32'(bus.miss_req), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) ptr[i] = 0;
      multi_seen = 1'b0;
      check_cleared("midrst");
      bus.fill_done = 1'b1;
      @(negedge clk);
      bus.fill_done = 1'b0;
      check("stray_way_en", 32'(bus.way_en), 0);
      check("stray_miss_req", 32'(bus.miss_req), 0);
      check("stray_resp_valid", 32'(bus.resp_valid), 0);
      @(negedge clk);
      check("stray_way_en2", 32'(bus.way_en), 0);
      access(7, 0, 8'b0000_0000, 2);
      access(4, 1, 8'b1000_0000, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
